alu_seq_exec: RTL and testbench



---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_comb_core.sv | 47 ++++
 rtl/alu_seq_exec.sv | 199 +++++++++++++++++++
 tb/tb_alu_seq_exec.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU control codes and execution-unit FSM encoding.
// The ALU control decoder drives the same 4-bit codes that alu_seq_exec consumes.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0100;
  localparam logic [3:0] ALU_SRA = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_MUL = 4'b1000;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_MUL   = 2'b10,
    ST_DONE  = 2'b11
  } alu_state_e;

  function automatic logic is_shift_op(input logic [3:0] code);
    return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_comb_core.sv
// Single-cycle ALU operations and signed-overflow detection.
// Shift codes pass op A through unchanged: that is the zero-shift-amount result.
module alu_comb_core
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] res,
  output logic            ovf,
  output logic            illegal
);

  logic [XLEN-1:0] sum;
  logic [XLEN-1:0] diff;
  logic            lt;

  // Result, overflow and illegal-code decode
  always_comb begin
    sum     = a + b;
    diff    = a - b;
    lt      = $signed(a) < $signed(b);
    res     = {XLEN{1'b0}};
    ovf     = 1'b0;
    illegal = 1'b0;
    case (alu_ctrl)
      ALU_AND: res = a & b;
      ALU_OR:  res = a | b;
      ALU_NOR: res = ~(a | b);
      ALU_ADD: begin
        res = sum;
        ovf = (a[XLEN-1] == b[XLEN-1]) && (sum[XLEN-1] != a[XLEN-1]);
      end
      ALU_SUB: begin
        res = diff;
        ovf = (a[XLEN-1] != b[XLEN-1]) && (diff[XLEN-1] != a[XLEN-1]);
      end
      ALU_SLT: res = {{(XLEN-1){1'b0}}, lt};
      ALU_SLL, ALU_SRL, ALU_SRA: res = a;
      ALU_MUL: res = {XLEN{1'b0}};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_seq_exec.sv
// Multi-cycle ALU execution unit with valid/ready on both sides.
// Shifts step one bit per cycle; MUL runs XLEN shift-add iterations.
module alu_seq_exec
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            ovf,
  output logic            illegal
);

  localparam int MUL_STEPS = XLEN;
  localparam int SW        = $clog2(XLEN);
  localparam int CW        = $clog2(XLEN + 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  alu_state_e      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      sh_ctrl_q, sh_ctrl_d;
  logic [XLEN-1:0] sh_q, sh_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0] mplier_q, mplier_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic            ovf_q, ovf_d;
  logic            illegal_q, illegal_d;
  logic            out_valid_q, out_valid_d;
  logic            in_ready_q, in_ready_d;

  logic [XLEN-1:0] core_res;
  logic            core_ovf;
  logic            core_illegal;
  logic [XLEN-1:0] sh_step;
  logic [XLEN-1:0] acc_step;
  logic [SW-1:0]   shamt;

  alu_comb_core #(.XLEN(XLEN)) u_core (
    .alu_ctrl (alu_ctrl),
    .a        (op_a),
    .b        (op_b),
    .res      (core_res),
    .ovf      (core_ovf),
    .illegal  (core_illegal)
  );

  // One-bit step of the iterative shifter and one shift-add step of the multiplier
  always_comb begin
    case (sh_ctrl_q)
      ALU_SLL: sh_step = {sh_q[XLEN-2:0], 1'b0};
      ALU_SRL: sh_step = {1'b0, sh_q[XLEN-1:1]};
      ALU_SRA: sh_step = {sh_q[XLEN-1], sh_q[XLEN-1:1]};
      default: sh_step = sh_q;
    endcase
    acc_step = acc_q + (mplier_q[0] ? mcand_q : {XLEN{1'b0}});
  end

  // Next-state and datapath control
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_ctrl_d   = sh_ctrl_q;
    sh_d        = sh_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    result_d    = result_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    illegal_d   = illegal_q;
    out_valid_d = out_valid_q;
    shamt       = op_b[SW-1:0];

    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          if (is_shift_op(alu_ctrl) && (shamt != {SW{1'b0}})) begin
            sh_ctrl_d = alu_ctrl;
            sh_d      = op_a;
            cnt_d     = CW'(shamt);
            state_d   = ST_SHIFT;
          end else if (alu_ctrl == ALU_MUL) begin
            acc_d    = {XLEN{1'b0}};
            mcand_d  = op_a;
            mplier_d = op_b;
            cnt_d    = CW'(MUL_STEPS);
            state_d  = ST_MUL;
          end else begin
            result_d    = core_res;
            zero_d      = (core_res == {XLEN{1'b0}});
            ovf_d       = core_ovf;
            illegal_d   = core_illegal;
            out_valid_d = 1'b1;
            state_d     = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        sh_d  = sh_step;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          result_d    = sh_step;
          zero_d      = (sh_step == {XLEN{1'b0}});
          ovf_d       = 1'b0;
          illegal_d   = 1'b0;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_MUL: begin
        acc_d    = acc_step;
        mcand_d  = {mcand_q[XLEN-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[XLEN-1:1]};
        cnt_d    = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          result_d    = acc_step;
          zero_d      = (acc_step == {XLEN{1'b0}});
          ovf_d       = 1'b0;
          illegal_d   = 1'b0;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          state_d = ST_MUL;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase

    // Registered so that in_ready stays low until the first edge after reset release
    in_ready_d = (state_d == ST_IDLE);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {CW{1'b0}};
      sh_ctrl_q   <= 4'b0000;
      sh_q        <= {XLEN{1'b0}};
      acc_q       <= {XLEN{1'b0}};
      mcand_q     <= {XLEN{1'b0}};
      mplier_q    <= {XLEN{1'b0}};
      result_q    <= {XLEN{1'b0}};
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_ctrl_q   <= sh_ctrl_d;
      sh_q        <= sh_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      illegal_q   <= illegal_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_seq_exec.sv
// Randomized self-checking bench for alu_seq_exec against an arithmetic reference model.
// Covers latency, backpressure, ignored inputs while busy, and reset mid-operation.
module tb_alu_seq_exec;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_ctrl;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        ovf;
  logic        illegal;

  int n_checks;
  int n_pass;

  alu_seq_exec #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctrl  (alu_ctrl),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .ovf       (ovf),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Reference: result, overflow, illegal flag and edges from accept to out_valid
  function automatic void ref_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic o, output logic il,
                                 output int lat);
    int     sh;
    longint wide;
    sh  = int'(b[4:0]);
    r   = 32'h0;
    o   = 1'b0;
    il  = 1'b0;
    lat = 0;
    case (c)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b1100: r = ~(a | b);
      4'b0010: begin
        r    = a + b;
        wide = longint'($signed(a)) + longint'($signed(b));
        o    = (wide != longint'($signed(r)));
      end
      4'b0110: begin
        r    = a - b;
        wide = longint'($signed(a)) - longint'($signed(b));
        o    = (wide != longint'($signed(r)));
      end
      4'b0111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0011: begin r = a << sh; lat = sh; end
      4'b0100: begin r = a >> sh; lat = sh; end
      4'b0101: begin r = $unsigned($signed(a) >>> sh); lat = sh; end
      4'b1000: begin r = a * b; lat = 32; end
      default: il = 1'b1;
    endcase
  endfunction

  task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input int hold, output logic [31:0] got);
    logic [31:0] er;
    logic        eo;
    logic        ei;
    int          elat;
    int          lat;
    ref_op(c, a, b, er, eo, ei, elat);
    @(negedge clk);
    check_eq("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    alu_ctrl = c;
    op_a     = a;
    op_b     = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat      = 0;
    @(negedge clk);
    while (!out_valid && lat < 100) begin
      check_eq("in_ready_busy", 32'(in_ready), 32'd0);
      in_valid  = 1'($urandom_range(0, 1));
      alu_ctrl  = 4'($urandom);
      op_a      = $urandom;
      op_b      = $urandom;
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check_eq("latency", 32'(lat), 32'(elat));
    check_eq("result", result, er);
    check_eq("zero", 32'(zero), 32'(er == 32'h0));
    check_eq("ovf", 32'(ovf), 32'(eo));
    check_eq("illegal", 32'(illegal), 32'(ei));
    got = result;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_eq("hold_valid", 32'(out_valid), 32'd1);
      check_eq("hold_result", result, er);
      check_eq("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_eq("drop_valid", 32'(out_valid), 32'd0);
    check_eq("back_idle", 32'(in_ready), 32'd1);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] got;
    logic [3:0]  codes [12];
    n_checks  = 0;
    n_pass    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    alu_ctrl  = 4'b0000;
    op_a      = 32'h0;
    op_b      = 32'h0;
    codes[0]  = 4'b0000; codes[1]  = 4'b0001; codes[2]  = 4'b0010; codes[3]  = 4'b0110;
    codes[4]  = 4'b0111; codes[5]  = 4'b1100; codes[6]  = 4'b0011; codes[7]  = 4'b0100;
    codes[8]  = 4'b0101; codes[9]  = 4'b1000; codes[10] = 4'b1111; codes[11] = 4'b1010;

    #2;
    check_eq("rst_in_ready", 32'(in_ready), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_result", result, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rel_in_ready_low", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    check_eq("rel_in_ready_high", 32'(in_ready), 32'd1);

    run_op(4'b0010, 32'h7FFF_FFFF, 32'h1, 0, got);
    check_eq("add_const", got, 32'h8000_0000);
    run_op(4'b0110, 32'd5, 32'd5, 0, got);
    run_op(4'b0111, 32'hFFFF_FFFF, 32'd1, 0, got);
    check_eq("slt_const", got, 32'd1);
    run_op(4'b0101, 32'h8000_0000, 32'd4, 0, got);
    check_eq("sra_const", got, 32'hF800_0000);
    run_op(4'b0101, 32'h8000_0000, 32'd0, 0, got);
    run_op(4'b1000, 32'd12345, 32'd678, 0, got);
    check_eq("mul_const", got, 32'd8369910);
    run_op(4'b0000, 32'h0000_F0F0, 32'h0000_FF00, 5, got);
    check_eq("and_const", got, 32'h0000_F000);
    run_op(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 0, got);

    // Reset in the middle of a multiply
    @(negedge clk);
    in_valid = 1'b1;
    alu_ctrl = 4'b1000;
    op_a     = 32'd777;
    op_b     = 32'd999;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check_eq("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("mid_rst_result", result, 32'h0);
    check_eq("mid_rst_flags", {29'd0, zero, ovf, illegal}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("mid_rel_in_ready_low", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    check_eq("mid_rel_in_ready_high", 32'(in_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("no_stray_valid", 32'(out_valid), 32'd0);
    end
    run_op(4'b0001, 32'h00FF_0000, 32'h0000_00FF, 0, got);
    check_eq("or_const", got, 32'h00FF_00FF);

    for (int i = 0; i < 40; i++) begin
      run_op(codes[$urandom_range(0, 11)], $urandom, $urandom, $urandom_range(0, 2), got);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
